// File: rtl/peripheral_bb_verilog_pkg.sv
// Shared constants and FSM state types for the burst-capable AXI slave BFM.
// Provides AXI burst-type and response encodings plus the write/read FSM
// state enumerations used by peripheral_bfm_slave_burst_bb.
package peripheral_bb_verilog_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/peripheral_bfm_burst_addr_gen_bb.sv
// Combinational AXI next-beat address generator.
// Ports:
//   addr      in  ADDR_W  current beat byte address
//   len       in  8       burst length minus one
//   size      in  3       log2 of bytes per beat
//   burst     in  2       FIXED / INCR / WRAP / reserved (treated as INCR)
//   next_addr out ADDR_W  byte address of the following beat
module peripheral_bfm_burst_addr_gen_bb
  import peripheral_bb_verilog_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size;
    incr_addr = addr + step;
    // Wrap lengths are powers of two, so the wrap window is a simple mask.
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/peripheral_bfm_slave_burst_bb.sv
// AXI slave bus-functional model with an internal word memory and full
// burst support (FIXED/INCR/WRAP), byte strobes and SLVERR reporting.
// Ports:
//   aclk, aresetn                  clock, synchronous active-low reset
//   aw*  (awid..awburst, awvalid)  write address channel, awready out
//   w*   (wdata, wstrb, wlast)     write data channel, wready out
//   b*   (bid, bresp, bvalid)      write response channel, bready in
//   ar*  (arid..arburst, arvalid)  read address channel, arready out
//   r*   (rid, rdata, rresp, rlast, rvalid)  read data channel, rready in
module peripheral_bfm_slave_burst_bb
  import peripheral_bb_verilog_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int LOG_STRB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_WORDS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> LOG_STRB) < ADDR_W'(MEM_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> LOG_STRB);
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Write channel state
  w_state_e          w_state;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_addr_next;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err;
  logic              w_beat;
  logic              w_last_pos;
  logic              w_beat_bad;
  logic              w_err_next;
  logic              mem_we;

  // Read channel state
  r_state_e          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr_next;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_size;
  logic [1:0]        ld_burst;
  logic              ld_bad;
  logic [DATA_W-1:0] ld_data;
  logic [1:0]        ld_resp;

  peripheral_bfm_burst_addr_gen_bb #(.ADDR_W(ADDR_W)) u_waddr (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_addr_next)
  );

  peripheral_bfm_burst_addr_gen_bb #(.ADDR_W(ADDR_W)) u_raddr (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_addr_next)
  );

  assign w_beat     = wvalid & wready;
  assign w_last_pos = (w_cnt == w_len);
  assign w_beat_bad = !in_range(w_addr) || (w_size > 3'(LOG_STRB));
  assign w_err_next = w_err | w_beat_bad | (wlast != w_last_pos);
  // A beat accepted while reset is asserted is part of an abandoned burst.
  assign mem_we     = w_beat & aresetn & !w_beat_bad;

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= (awsize > 3'(LOG_STRB)) || (awburst == BURST_RSVD);
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            w_err <= w_err_next;
            if (w_last_pos) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= w_err_next ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_addr <= w_addr_next;
              w_cnt  <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read data is fetched for the first beat from the AR request itself and
  // for later beats from the next address, so rdata is ready with rvalid.
  always_comb begin
    if (r_state == R_IDLE) begin
      ld_addr  = araddr;
      ld_size  = arsize;
      ld_burst = arburst;
    end else begin
      ld_addr  = r_addr_next;
      ld_size  = r_size;
      ld_burst = r_burst;
    end
    ld_bad  = !in_range(ld_addr) || (ld_size > 3'(LOG_STRB));
    ld_data = ld_bad ? '0 : mem[word_idx(ld_addr)];
    ld_resp = (ld_bad || ld_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
            rid     <= arid;
            rdata   <= ld_data;
            rresp   <= ld_resp;
            rlast   <= (arlen == 8'd0);
            rvalid  <= 1'b1;
            arready <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_addr_next;
              r_cnt  <= r_cnt + 8'd1;
              rdata  <= ld_data;
              rresp  <= ld_resp;
              rlast  <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bfm_slave_burst_bb.sv
// Self-checking bench for peripheral_bfm_slave_burst_bb: directed burst
// scenarios plus randomized write/read pairs against a behavioural memory
// model that derives beat addresses arithmetically from the AXI burst rules.
module tb_peripheral_bfm_slave_burst_bb;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  peripheral_bfm_slave_burst_bb #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(256)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte address of beat i of a burst, straight from the AXI burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input logic [1:0] burst, input int i);
    longint incr, total, base, s;
    incr  = longint'(1) << size;
    total = (len + 1) * incr;
    s     = longint'(start);
    case (burst)
      2'b00:   return start;
      2'b10: begin
        base = (s / total) * total;
        return 32'(base + ((s - base + i * incr) % total));
      end
      default: return 32'(s + i * incr);
    endcase
  endfunction

  function automatic bit word_ok(input logic [31:0] a, input int size);
    return ((a >> 2) < 256) && (size <= 2);
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int bready_delay,
                           input bit bad_last, input bit gaps);
    int n;
    bit err;
    logic [31:0] a;
    err = (size > 2) || (burst == 2'b11) || bad_last;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1'b1;
    chk("wready_before_aw", wready, 1'b0);
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("aw_timeout", 1'b0, 1'b1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge aclk);
      end
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len) && !bad_last; wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) chk("w_timeout", 1'b0, 1'b1);
      @(negedge aclk);
      a = beat_addr(addr, len, size, burst, i);
      if (word_ok(a, size)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model_mem[a >> 2][b*8 +: 8] = wd[i][b*8 +: 8];
      end else begin
        err = 1'b1;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("b_timeout", 1'b0, 1'b1);
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    for (int k = 0; k < bready_delay; k++) begin
      chk("awready_during_b", awready, 1'b0);
      @(negedge aclk);
      chk("bvalid_held", {bvalid, bresp}, {1'b1, err ? 2'b10 : 2'b00});
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("b_done", {bvalid, awready}, 2'b01);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst, input int stall_beat,
                          input int stall_cycles, input bit rand_stall);
    int n, st;
    logic [31:0] a, exp_d, hold_d;
    logic [1:0]  exp_r;
    logic        hold_l;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) chk("ar_timeout", 1'b0, 1'b1);
    @(negedge aclk);
    arvalid = 1'b0;
    chk("rvalid_after_ar", rvalid, 1'b1);
    for (int i = 0; i <= len; i++) begin
      a     = beat_addr(addr, len, size, burst, i);
      exp_d = word_ok(a, size) ? model_mem[a >> 2] : 32'h0;
      exp_r = (!word_ok(a, size) || burst == 2'b11) ? 2'b10 : 2'b00;
      st    = (i == stall_beat) ? stall_cycles : (rand_stall ? $urandom_range(0, 2) : 0);
      rready = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) chk("r_timeout", 1'b0, 1'b1);
      hold_d = rdata; hold_l = rlast;
      for (int k = 0; k < st; k++) begin
        @(negedge aclk);
        chk("r_stable", {rvalid, rlast, rdata}, {1'b1, hold_l, hold_d});
      end
      rready = 1'b1;
      chk("rdata", rdata, exp_d);
      chk("rresp", rresp, exp_r);
      chk("rlast", rlast, (i == len));
      chk("rid", rid, id);
      @(negedge aclk);
    end
    rready = 1'b0;
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, size, bsel;
    logic [1:0]  burst;
    logic [31:0] addr;
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;

    repeat (3) @(negedge aclk);
    chk("rst_aw_w_b", {awready, wready, bvalid, bid, bresp}, 9'h0);
    chk("rst_ar_r", {arready, rvalid, rid, rresp, rlast}, 9'h0);
    chk("rst_rdata", rdata, 32'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("ready_after_rst", {awready, arready}, 2'b11);

    // Clear the whole memory with one 256-beat burst.
    for (int i = 0; i < 256; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
    axi_write(4'h1, 32'h0, 255, 2, 2'b01, 0, 1'b0, 1'b0);

    // INCR write/readback of 1..4 at 0x10.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(4'h3, 32'h10, 3, 2, 2'b01, 0, 1'b0, 1'b0);
    axi_read(4'h5, 32'h10, 3, 2, 2'b01, -1, 0, 1'b0);

    // WRAP read from 0x18 returns words 0x18, 0x1C, 0x10, 0x14.
    axi_read(4'h6, 32'h18, 3, 2, 2'b10, -1, 0, 1'b0);

    // Partial strobe write over zero.
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    axi_write(4'h7, 32'h0, 0, 2, 2'b01, 0, 1'b0, 1'b0);
    chk("strobe_model", model_mem[0], 32'h00BB00DD);
    axi_read(4'h7, 32'h0, 0, 2, 2'b01, -1, 0, 1'b0);

    // Two-beat INCR write starting at the last word.
    wd[0] = 32'hCAFEF00D; wd[1] = 32'h12345678; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(4'h8, 32'h3FC, 1, 2, 2'b01, 0, 1'b0, 1'b0);
    axi_read(4'h8, 32'h3FC, 1, 2, 2'b01, -1, 0, 1'b0);

    // INCR address wraps modulo 2^32 back into memory.
    axi_read(4'h9, 32'hFFFFFFFC, 1, 2, 2'b01, -1, 0, 1'b0);

    // rready stall on beat 2, delayed bready.
    axi_read(4'hA, 32'h10, 3, 2, 2'b01, 1, 5, 1'b0);
    for (int i = 0; i < 2; i++) begin wd[i] = 32'h5A5A0000 + 32'(i); ws[i] = 4'hF; end
    axi_write(4'hB, 32'h80, 1, 2, 2'b01, 3, 1'b0, 1'b0);

    // wlast missing on the final beat.
    axi_write(4'hC, 32'h90, 1, 2, 2'b01, 0, 1'b1, 1'b0);

    // Reset pulsed during beat 2 of a 4-beat write.
    @(negedge aclk);
    awid = 4'hD; awaddr = 32'h40; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    while (!awready) @(negedge aclk);
    @(negedge aclk);
    awvalid = 1'b0;
    wdata = 32'h11111111; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(negedge aclk);
    model_mem[32'h40 >> 2] = 32'h11111111;
    wdata = 32'h22222222; aresetn = 1'b0;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("midrst_outputs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_release", {awready, bvalid, arready}, 3'b101);
    axi_read(4'hD, 32'h40, 3, 2, 2'b01, -1, 0, 1'b0);

    // Randomized write/read pairs.
    for (int t = 0; t < 25; t++) begin
      bsel  = $urandom_range(0, 2);
      burst = 2'(bsel);
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2'b10) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = $urandom_range(0, 7);
      end
      addr = 32'($urandom_range(0, 32'h4FF)) & ~((32'h1 << size) - 32'h1);
      for (int i = 0; i <= len; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom_range(0, 15));
      end
      axi_write(4'($urandom_range(0, 15)), addr, len, size, burst,
                $urandom_range(0, 2), 1'b0, 1'b1);
      axi_read(4'($urandom_range(0, 15)), addr, len, size, burst, -1, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
